modular_result_normalizer: RTL and testbench

Parametrised normaliser for the signed remainder vectors produced by the parallel divider. It adds the modulus (last diagonal element) to every negative active lane, repeating over several passes where needed, and optionally subtracts it from lanes at or above the modulus. It reports per-vector sign and zero flags and hands the result downstream over a valid/ready handshake. It sits between the parallel divider and the elimination/back-substitution control FSM.

---
 rtl/modular_result_normalizer_pkg.sv | 20 ++
 rtl/modular_result_normalizer_lane_adjust.sv | 44 ++++
 rtl/modular_result_normalizer.sv | 143 ++++++++++++++
 tb/tb_modular_result_normalizer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/modular_result_normalizer_pkg.sv
// Shared types and defaults for the modular result normaliser.
// Optional feature macro used by this block: PRA_UPPER_REDUCE_EN.
package modular_result_pkg;

    localparam int LANES_DEF      = 12;
    localparam int DATA_WIDTH_DEF = 64;
    localparam int MAX_PASSES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADJUST = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Bit offset of a lane inside a packed lane vector.
    function automatic int lane_base(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/modular_result_normalizer_lane_adjust.sv
// Combinational single-lane correction step; out_of_range reports whether the corrected
// value still needs another pass. PRA_UPPER_REDUCE_EN adds the value >= modulus reduction.
module remainder_lane_adjust #(
    parameter int DATA_WIDTH = 64
) (
    input  logic signed [DATA_WIDTH-1:0] value,
    input  logic signed [DATA_WIDTH-1:0] modulus,
    input  logic                         active,
    output logic signed [DATA_WIDTH-1:0] next_value,
    output logic                         out_of_range,
    output logic                         is_neg,
    output logic                         is_zero
);

    logic                         neg;
    logic signed [DATA_WIDTH-1:0] adjusted;
    logic                         residual;

    assign neg = (value < 0);

`ifdef PRA_UPPER_REDUCE_EN
    logic high;
    assign high = (value >= modulus);

    always_comb begin
        adjusted = value;
        if (neg)
            adjusted = value + modulus;
        else if (high)
            adjusted = value - modulus;
    end

    assign residual = (adjusted < 0) || (adjusted >= modulus);
`else
    assign adjusted = neg ? (value + modulus) : value;
    assign residual = (adjusted < 0);
`endif

    assign next_value   = active ? adjusted : value;
    assign out_of_range = active && residual;
    assign is_neg       = active && neg;
    assign is_zero      = active && (value == '0);

endmodule

// File: rtl/modular_result_normalizer.sv
// Normalises signed remainder vectors into range by repeated modulus correction passes.
// Define PRA_UPPER_REDUCE_EN to also reduce lanes at or above the modulus.
module modular_result_normalizer
    import modular_result_pkg::*;
#(
    parameter int LANES      = LANES_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_PASSES = MAX_PASSES_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    input  logic [LANES-1:0]              lane_mask,
    input  logic signed [DATA_WIDTH-1:0]  modulus,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   out_data,
    output logic                          neg_seen,
    output logic                          zero_seen,
    output logic                          unconverged,
    output logic                          mod_error
);

    localparam int             PCW        = $clog2(MAX_PASSES + 1);
    localparam logic [PCW-1:0] PASS_LIMIT = PCW'(MAX_PASSES);

    state_t                        state, state_next;
    logic [LANES*DATA_WIDTH-1:0]   data_q;
    logic [LANES-1:0]              mask_q;
    logic signed [DATA_WIDTH-1:0]  mod_q;
    logic [PCW-1:0]                pass_cnt;
    logic [PCW-1:0]                pass_next;

    logic                          capturing;
    logic                          accept;
    logic                          mod_bad;
    logic                          any_oor;
    logic                          adjust_done;

    logic signed [DATA_WIDTH-1:0]  next_lane [LANES];
    logic [LANES*DATA_WIDTH-1:0]   next_packed;
    logic [LANES-1:0]              lane_oor;
    logic [LANES-1:0]              lane_neg;
    logic [LANES-1:0]              lane_zero;

    // In IDLE the lane units look at the incoming vector so the sign/zero flags
    // can be captured together with it; afterwards they work on the held vector.
    assign capturing = (state == IDLE);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [DATA_WIDTH-1:0] lane_value;
        assign lane_value = capturing ? in_data[lane_base(i, DATA_WIDTH) +: DATA_WIDTH]
                                      : data_q[lane_base(i, DATA_WIDTH) +: DATA_WIDTH];

        remainder_lane_adjust #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_adjust (
            .value        (lane_value),
            .modulus      (capturing ? modulus : mod_q),
            .active       (capturing ? lane_mask[i] : mask_q[i]),
            .next_value   (next_lane[i]),
            .out_of_range (lane_oor[i]),
            .is_neg       (lane_neg[i]),
            .is_zero      (lane_zero[i])
        );
    end

    always_comb begin
        next_packed = '0;
        for (int i = 0; i < LANES; i++)
            next_packed[i*DATA_WIDTH +: DATA_WIDTH] = next_lane[i];
    end

    assign in_ready    = (state == IDLE) && !reset;
    assign accept      = in_valid && in_ready;
    assign mod_bad     = (mod_q <= 0);
    assign pass_next   = pass_cnt + 1'b1;
    assign any_oor     = |lane_oor;
    assign adjust_done = mod_bad || !any_oor || (pass_next >= PASS_LIMIT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)      state_next = ADJUST;
            ADJUST:  if (adjust_done) state_next = DONE;
            DONE:    if (out_ready)   state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            data_q      <= '0;
            mask_q      <= '0;
            mod_q       <= '0;
            pass_cnt    <= '0;
            out_valid   <= 1'b0;
            neg_seen    <= 1'b0;
            zero_seen   <= 1'b0;
            unconverged <= 1'b0;
            mod_error   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_q      <= in_data;
                        mask_q      <= lane_mask;
                        mod_q       <= modulus;
                        pass_cnt    <= '0;
                        neg_seen    <= |lane_neg;
                        zero_seen   <= |lane_zero;
                        unconverged <= 1'b0;
                        mod_error   <= 1'b0;
                    end
                end
                ADJUST: begin
                    if (mod_bad) begin
                        mod_error   <= 1'b1;
                        unconverged <= 1'b0;
                    end else begin
                        data_q      <= next_packed;
                        pass_cnt    <= pass_next;
                        unconverged <= adjust_done && any_oor;
                    end
                    if (adjust_done)
                        out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready)
                        out_valid <= 1'b0;
                end
                default: out_valid <= 1'b0;
            endcase
        end
    end

    assign out_data = data_q;

endmodule

// File: tb/tb_modular_result_normalizer.sv
// Directed bench for modular_result_normalizer (LANES=4, DATA_WIDTH=16, MAX_PASSES=4);
// the upper-range vector follows PRA_UPPER_REDUCE_EN.
module tb_modular_result_normalizer;

    localparam int L  = 4;
    localparam int DW = 16;
    localparam int MP = 4;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [L*DW-1:0]      in_data = '0;
    logic [L-1:0]         lane_mask = '0;
    logic signed [DW-1:0] modulus = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [L*DW-1:0]      out_data;
    logic                 neg_seen, zero_seen, unconverged, mod_error;

    int n_cmp = 0;
    int n_err = 0;

    modular_result_normalizer #(
        .LANES      (L),
        .DATA_WIDTH (DW),
        .MAX_PASSES (MP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .lane_mask   (lane_mask),
        .modulus     (modulus),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .neg_seen    (neg_seen),
        .zero_seen   (zero_seen),
        .unconverged (unconverged),
        .mod_error   (mod_error)
    );

    always #5 clk = ~clk;

    function automatic logic [L*DW-1:0] pk(input logic signed [DW-1:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic n, input logic z, input logic u, input logic m);
        chk({tag, "_neg_seen"}, neg_seen, n);
        chk({tag, "_zero_seen"}, zero_seen, z);
        chk({tag, "_unconverged"}, unconverged, u);
        chk({tag, "_mod_error"}, mod_error, m);
    endtask

    // Present one vector, then count edges after capture until out_valid appears.
    task automatic run_vec(input string tag, input logic [L*DW-1:0] d, input logic [L-1:0] m,
                           input logic signed [DW-1:0] md, output int lat);
        int wait_cnt;
        @(negedge clk);
        wait_cnt = 0;
        while (!in_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!in_ready) chk({tag, "_in_ready_wait"}, in_ready, 1);
        in_data   = d;
        lane_mask = m;
        modulus   = md;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) chk({tag, "_out_valid_timeout"}, out_valid, 1);
    endtask

    task automatic accept_result(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk({tag, "_out_valid_clr"}, out_valid, 0);
        chk({tag, "_in_ready_after"}, in_ready, 1);
    endtask

    initial begin
        int lat;
        logic [L*DW-1:0] exp_data;

        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk_flags("rst", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst_rel_in_ready", in_ready, 1);

        // Mixed lanes, one pass, then backpressure for 5 cycles
        run_vec("v1", pk(-3, 5, 0, 2), 4'b1111, 7, lat);
        exp_data = pk(4, 5, 0, 2);
        chk("v1_latency", lat, 1);
        chk("v1_data", out_data, exp_data);
        chk_flags("v1", 1, 1, 0, 0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk("v1_hold_valid", out_valid, 1);
            chk("v1_hold_data", out_data, exp_data);
            chk("v1_hold_in_ready", in_ready, 0);
            chk("v1_hold_neg", neg_seen, 1);
            chk("v1_hold_zero", zero_seen, 1);
        end
        accept_result("v1");

        // Converges on the third pass
        run_vec("v2", pk(-12, 1, 2, 3), 4'b1111, 5, lat);
        chk("v2_latency", lat, 3);
        chk("v2_data", out_data, pk(3, 1, 2, 3));
        chk_flags("v2", 1, 0, 0, 0);
        accept_result("v2");

        // Runs out of passes
        run_vec("v3", pk(-20, 0, 1, 1), 4'b1111, 2, lat);
        chk("v3_latency", lat, 4);
        chk("v3_data", out_data, pk(-12, 0, 1, 1));
        chk_flags("v3", 1, 1, 1, 0);
        accept_result("v3");

        // Inactive negative lane is neither corrected nor flagged
        run_vec("v4", pk(3, -1, 4, 5), 4'b0001, 7, lat);
        chk("v4_latency", lat, 1);
        chk("v4_data", out_data, pk(3, -1, 4, 5));
        chk_flags("v4", 0, 0, 0, 0);
        accept_result("v4");

        // Zero modulus leaves data untouched
        run_vec("v5", pk(-3, 5, 0, 2), 4'b1111, 0, lat);
        chk("v5_latency", lat, 1);
        chk("v5_data", out_data, pk(-3, 5, 0, 2));
        chk_flags("v5", 1, 1, 0, 1);
        accept_result("v5");

        // Lane at or above the modulus
        run_vec("v6", pk(9, 1, 2, 3), 4'b1111, 7, lat);
        chk("v6_latency", lat, 1);
`ifdef PRA_UPPER_REDUCE_EN
        chk("v6_data", out_data, pk(2, 1, 2, 3));
`else
        chk("v6_data", out_data, pk(9, 1, 2, 3));
`endif
        chk_flags("v6", 0, 0, 0, 0);
        accept_result("v6");

        // Reset in the middle of a multi-pass adjustment
        @(negedge clk);
        in_data   = pk(-20, 0, 1, 1);
        lane_mask = 4'b1111;
        modulus   = 2;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("mid_neg_before", neg_seen, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_out_data", out_data, 0);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_in_ready", in_ready, 0);
        chk_flags("mid", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("mid_rel_in_ready", in_ready, 1);

        // Fresh vector after the aborted one starts from pass zero
        run_vec("v7", pk(-12, 1, 2, 3), 4'b1111, 5, lat);
        chk("v7_latency", lat, 3);
        chk("v7_data", out_data, pk(3, 1, 2, 3));
        accept_result("v7");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
